signed_level_monitor: RTL and testbench

SIGNED_LEVEL_MONITOR -- requirements
Module: signed_level_monitor

---
 rtl/signed_level_monitor.sv | 168 ++++++++++++++++
 tb/tb_signed_level_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/signed_level_monitor.sv
// Signed level monitor: debounced NORM/HI/LO classifier with hysteresis, event counter and
// optional running peaks (enabled by defining SIGNED_LEVEL_MONITOR_PEAK_TRACK_EN).
module signed_level_monitor #(
  parameter int HI_TH     = 100,
  parameter int LO_TH     = -100,
  parameter int HYST      = 10,
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] q_in,
  input  logic       clr_pk,
  output logic [1:0] state,
  output logic       alarm_hi,
  output logic       alarm_lo,
  output logic       evt,
  output logic [7:0] evt_cnt,
  output logic [7:0] max_q,
  output logic [7:0] min_q
);

  typedef enum logic [1:0] {
    NORM = 2'b00,
    HI   = 2'b01,
    LO   = 2'b10
  } state_t;

  // 9-bit signed thresholds so HI_TH-HYST / LO_TH+HYST never wrap
  localparam logic signed [8:0] HI_ENTER = 9'(HI_TH);
  localparam logic signed [8:0] LO_ENTER = 9'(LO_TH);
  localparam logic signed [8:0] HI_EXIT  = 9'(HI_TH - HYST);
  localparam logic signed [8:0] LO_EXIT  = 9'(LO_TH + HYST);
  localparam logic [3:0]        DB       = 4'(DB_CYCLES);

  state_t      state_q, state_d;
  state_t      tgt_q, tgt_d;
  state_t      dest;
  logic [3:0]  cnt_q, cnt_d, next_cnt;
  logic        qual;
  logic        evt_q, evt_d;
  logic [7:0]  evt_cnt_q, evt_cnt_d;
  logic        alarm_hi_q, alarm_lo_q;
  logic signed [8:0] q9;

  assign q9 = {q_in[7], q_in};

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    evt_d     = 1'b0;
    evt_cnt_d = evt_cnt_q;
    qual      = 1'b0;
    dest      = NORM;
    next_cnt  = cnt_q + 4'd1;

    case (state_q)
      NORM: begin
        if (q9 > HI_ENTER) begin
          qual = 1'b1;
          dest = HI;
        end else if (q9 < LO_ENTER) begin
          qual = 1'b1;
          dest = LO;
        end
      end
      HI: begin
        if (q9 < HI_EXIT) begin
          qual = 1'b1;
          dest = (q9 < LO_ENTER) ? LO : NORM;
        end
      end
      LO: begin
        if (q9 > LO_EXIT) begin
          qual = 1'b1;
          dest = (q9 > HI_ENTER) ? HI : NORM;
        end
      end
      default: ;
    endcase

    // A nonzero count in NORM means the previous en cycle qualified toward tgt_q
    if (state_q == NORM && cnt_q != '0 && dest != tgt_q) begin
      next_cnt = 4'd1;
    end

    if (en) begin
      if (!qual) begin
        cnt_d = '0;
      end else begin
        tgt_d = dest;
        if (next_cnt == DB) begin
          state_d = dest;
          cnt_d   = '0;
          evt_d   = 1'b1;
          if (evt_cnt_q != '1) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
          end
        end else begin
          cnt_d = next_cnt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= NORM;
      tgt_q      <= NORM;
      cnt_q      <= '0;
      evt_q      <= 1'b0;
      evt_cnt_q  <= '0;
      alarm_hi_q <= 1'b0;
      alarm_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      evt_q      <= evt_d;
      evt_cnt_q  <= evt_cnt_d;
      alarm_hi_q <= (state_d == HI);
      alarm_lo_q <= (state_d == LO);
    end
  end

  assign state    = state_q;
  assign alarm_hi = alarm_hi_q;
  assign alarm_lo = alarm_lo_q;
  assign evt      = evt_q;
  assign evt_cnt  = evt_cnt_q;

`ifdef SIGNED_LEVEL_MONITOR_PEAK_TRACK_EN
  logic [7:0] max_q_q, max_q_d;
  logic [7:0] min_q_q, min_q_d;

  always_comb begin
    max_q_d = max_q_q;
    min_q_d = min_q_q;
    if (clr_pk) begin
      max_q_d = q_in;
      min_q_d = q_in;
    end else if (en) begin
      if ($signed(q_in) > $signed(max_q_q)) max_q_d = q_in;
      if ($signed(q_in) < $signed(min_q_q)) min_q_d = q_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      max_q_q <= 8'h80;
      min_q_q <= 8'h7f;
    end else begin
      max_q_q <= max_q_d;
      min_q_q <= min_q_d;
    end
  end

  assign max_q = max_q_q;
  assign min_q = min_q_q;
`else
  logic clr_pk_unused;
  assign clr_pk_unused = clr_pk;
  assign max_q = '0;
  assign min_q = '0;
`endif

endmodule

// File: tb/tb_signed_level_monitor.sv
// Bench for signed_level_monitor: directed vector table, peak sequence and randomized
// traffic, all checked against a behavioural model of the classifier rules.
module tb_signed_level_monitor;

  localparam int HI_TH = 100;
  localparam int LO_TH = -100;
  localparam int HYST  = 10;
  localparam int DB    = 4;

  logic       clk = 1'b0;
  logic       rst, en, clr_pk;
  logic [7:0] q_in;
  logic [1:0] state;
  logic       alarm_hi, alarm_lo, evt;
  logic [7:0] evt_cnt, max_q, min_q;

  int n_cmp = 0;
  int n_bad = 0;

  // model: 0 NORM, 1 HI, 2 LO
  int m_state, m_cnt, m_tgt, m_evt, m_evtcnt, m_max, m_min;

  typedef struct {
    logic r;
    logic e;
    byte  q;
    logic c;
    int   reps;
    int   st;
    int   ev;
    int   ec;
  } vec_t;

  vec_t tbl[$];

  signed_level_monitor #(
    .HI_TH(HI_TH),
    .LO_TH(LO_TH),
    .HYST(HYST),
    .DB_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .q_in(q_in),
    .clr_pk(clr_pk),
    .state(state),
    .alarm_hi(alarm_hi),
    .alarm_lo(alarm_lo),
    .evt(evt),
    .evt_cnt(evt_cnt),
    .max_q(max_q),
    .min_q(min_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input int q, input logic c);
    int target;
    if (!r) begin
      m_state = 0; m_cnt = 0; m_tgt = 0; m_evt = 0; m_evtcnt = 0;
`ifdef SIGNED_LEVEL_MONITOR_PEAK_TRACK_EN
      m_max = -128; m_min = 127;
`else
      m_max = 0; m_min = 0;
`endif
      return;
    end
    m_evt = 0;
    if (e) begin
      target = -1;
      if (m_state == 0) begin
        if (q > HI_TH) target = 1;
        else if (q < LO_TH) target = 2;
      end else if (m_state == 1) begin
        if (q < HI_TH - HYST) target = (q < LO_TH) ? 2 : 0;
      end else begin
        if (q > LO_TH + HYST) target = (q > HI_TH) ? 1 : 0;
      end
      if (target < 0) begin
        m_cnt = 0;
      end else begin
        if (m_state == 0 && m_cnt > 0 && target != m_tgt) m_cnt = 1;
        else m_cnt = m_cnt + 1;
        m_tgt = target;
        if (m_cnt == DB) begin
          m_state = target;
          m_cnt = 0;
          m_evt = 1;
          if (m_evtcnt < 255) m_evtcnt = m_evtcnt + 1;
        end
      end
    end
`ifdef SIGNED_LEVEL_MONITOR_PEAK_TRACK_EN
    if (c) begin
      m_max = q; m_min = q;
    end else if (e) begin
      if (q > m_max) m_max = q;
      if (q < m_min) m_min = q;
    end
`endif
  endtask

  task automatic cyc(input logic r, input logic e, input byte q, input logic c);
    rst = r; en = e; q_in = q; clr_pk = c;
    @(posedge clk);
    #1;
    model_step(r, e, int'(q), c);
    chk("state", int'(state), m_state);
    chk("alarm_hi", int'(alarm_hi), int'(m_state == 1));
    chk("alarm_lo", int'(alarm_lo), int'(m_state == 2));
    chk("evt", int'(evt), m_evt);
    chk("evt_cnt", int'(evt_cnt), m_evtcnt);
    chk("max_q", int'($signed(max_q)), m_max);
    chk("min_q", int'($signed(min_q)), m_min);
  endtask

  function automatic void add(input int r, input int e, input int q, input int c,
                              input int reps, input int st, input int ev, input int ec);
    vec_t v;
    v.r = r[0]; v.e = e[0]; v.q = byte'(q); v.c = c[0];
    v.reps = reps; v.st = st; v.ev = ev; v.ec = ec;
    tbl.push_back(v);
  endfunction

  byte interesting[12] = '{8'sd101, 8'sd100, -8'sd101, -8'sd100, 8'sd89, 8'sd90,
                           -8'sd89, -8'sd90, 8'sd127, -8'sd128, 8'sd0, -8'sd120};

  initial begin
    rst = 1'b0; en = 1'b0; q_in = '0; clr_pk = 1'b0;

    //   r  e    q  c reps st ev ec
    add(0, 1,    0, 1,  1, 0, 0, 0);
    add(1, 1,  101, 0,  3, 0, 0, 0);
    add(1, 1,  100, 0,  1, 0, 0, 0);
    add(1, 1,  101, 0,  3, 0, 0, 0);
    add(1, 1,  101, 0,  1, 1, 1, 1);
    add(1, 1,  101, 0,  1, 1, 0, 1);
    add(1, 1,   95, 0, 10, 1, 0, 1);
    add(1, 1,   89, 0,  3, 1, 0, 1);
    add(1, 1,   89, 0,  1, 0, 1, 2);
    add(1, 1,  101, 0,  4, 1, 1, 3);
    add(1, 1, -120, 0,  3, 1, 0, 3);
    add(1, 1, -120, 0,  1, 2, 1, 4);
    add(1, 1,    0, 0,  4, 0, 1, 5);
    add(1, 1,  101, 0,  3, 0, 0, 5);
    add(1, 0, -120, 0,  5, 0, 0, 5);
    add(1, 1,  101, 0,  1, 1, 1, 6);
    add(1, 1,   89, 0,  2, 1, 0, 6);
    add(0, 1,   89, 1,  1, 0, 0, 0);
    add(1, 1,  101, 0,  3, 0, 0, 0);
    add(1, 1, -120, 0,  3, 0, 0, 0);
    add(1, 1, -120, 0,  1, 2, 1, 1);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        cyc(tbl[i].r, tbl[i].e, tbl[i].q, tbl[i].c);
      end
      chk("tbl_state", int'(state), tbl[i].st);
      chk("tbl_evt", int'(evt), tbl[i].ev);
      chk("tbl_evt_cnt", int'(evt_cnt), tbl[i].ec);
    end

    // peak tracking sequence
    cyc(1'b0, 1'b1, 8'sd0, 1'b0);
    cyc(1'b1, 1'b1, 8'sd5, 1'b0);
    cyc(1'b1, 1'b1, -8'sd7, 1'b0);
    cyc(1'b1, 1'b1, 8'sd120, 1'b0);
    cyc(1'b1, 1'b1, -8'sd3, 1'b0);
`ifdef SIGNED_LEVEL_MONITOR_PEAK_TRACK_EN
    chk("pk_max", int'($signed(max_q)), 120);
    chk("pk_min", int'($signed(min_q)), -7);
`else
    chk("pk_max", int'($signed(max_q)), 0);
    chk("pk_min", int'($signed(min_q)), 0);
`endif
    cyc(1'b1, 1'b0, 8'sd10, 1'b1);
`ifdef SIGNED_LEVEL_MONITOR_PEAK_TRACK_EN
    chk("clr_max", int'($signed(max_q)), 10);
    chk("clr_min", int'($signed(min_q)), 10);
`else
    chk("clr_max", int'($signed(max_q)), 0);
    chk("clr_min", int'($signed(min_q)), 0);
`endif

    // randomized traffic biased toward the thresholds
    for (int i = 0; i < 3000; i++) begin
      byte  q;
      logic r, e, c;
      if ($urandom_range(0, 1) == 0) q = interesting[$urandom_range(0, 11)];
      else q = byte'($urandom_range(0, 255));
      r = ($urandom_range(0, 199) != 0);
      e = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 19) == 0);
      cyc(r, e, q, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
